dkong_rom_loader: RTL
=====================

Name: dkong_rom_loader

Overview:
- Sequences the ROM download port and core reset for the Donkey Kong core.
- Decodes the flat download address stream into per-region ROM write strobes: CPU, sound, tile, sprite, PROM.
- Holds the core in reset from download start until the image is complete and a settle interval has elapsed.
- Sits between the HPS download signals and dkong_top's ROM/RAM write ports. It replaces the ad-hoc reset OR-term.

Parameters:
- SETTLE_CYCLES, 1024, clocks the core reset stays asserted after a good load or a user reset (min 2).
- EXPECTED_SUM, 16'h0000, reference sum used only with the optional feature.

Ports:
- I_CLK_24576M  in  1  system clock; the only clock.
- I_RESETn  in  1  asynchronous active-low reset.
- I_DN_ACTIVE  in  1  download in progress.
- I_DN_ADDR  in  19  download byte address.
- I_DN_DATA  in  8  download byte.
- I_DN_WR  in  1  one-cycle write strobe.
- I_USER_RESET  in  1  OSD/button reset request, level.
- O_WR_ADDR  out  15  region-relative byte address.
- O_WR_DATA  out  8  byte to write.
- O_WR_SEL  out  5  one-hot write enable: [0]CPU [1]SND [2]TILE [3]OBJ [4]PROM.
- O_CORE_RESETn  out  1  core reset, active low.
- O_LOADED  out  1  a complete image has been loaded since power-up.
- O_ERR  out  1  last download was short, or its checksum mismatched.
- O_CHECKSUM  out  16  running byte sum.

Behaviour:
- Clock and reset: single clock I_CLK_24576M; I_RESETn is asynchronous, active-low.
- Reset values:
  - State = HOLD.
  - O_WR_SEL=0, O_WR_ADDR=0, O_WR_DATA=0.
  - O_CORE_RESETn=0, O_LOADED=0, O_ERR=0, O_CHECKSUM=0.
  - Settle counter=0, max_addr=0.
- Region map, inclusive:
  - CPU 0x00000–0x03FFF.
  - SND 0x04000–0x04FFF.
  - TILE 0x05000–0x05FFF.
  - OBJ 0x06000–0x07FFF.
  - PROM 0x08000–0x082FF.
  - Any address ≥0x08300 is accepted on the port but produces no strobe and does not update max_addr.
- Write path:
  - Registered; latency 1 clock from I_DN_WR to O_WR_SEL.
  - O_WR_SEL is high for exactly one clock per I_DN_WR.
  - O_WR_ADDR = I_DN_ADDR minus the region base, zero-extended to 15 bits.
  - Writes are accepted only in LOAD. I_DN_WR in any other state is ignored.
- State machine:
  - HOLD: core reset asserted.
    - I_DN_ACTIVE → LOAD.
    - Else if O_LOADED=1 and O_ERR=0 → SETTLE.
  - LOAD: core reset asserted; clear max_addr and checksum on entry.
    - Track max_addr = max of accepted in-map addresses.
    - Fall of I_DN_ACTIVE: if max_addr==0x082FF (and checksum OK when enabled), set O_LOADED=1, O_ERR=0, go to SETTLE.
    - Otherwise set O_ERR=1 and go to HOLD. O_LOADED keeps its prior value, but HOLD is not left until a new download.
  - SETTLE: core reset asserted; counter counts 0..SETTLE_CYCLES-1, then → RUN.
    - I_DN_ACTIVE → LOAD.
    - I_USER_RESET restarts the counter at 0.
  - RUN: O_CORE_RESETn=1.
    - I_USER_RESET → SETTLE (counter 0).
    - I_DN_ACTIVE → LOAD.
- Reset output timing: O_CORE_RESETn is registered. It deasserts on the first clock in RUN and asserts the clock after leaving RUN.
- Simultaneous events:
  - I_DN_WR on the same clock I_DN_ACTIVE falls: the write is accepted and counts toward max_addr before the completeness check.
  - Download and user reset together: download wins.
- Async reset mid-download: all outputs return to reset values immediately; partial ROM contents are not trusted (O_LOADED=0).
- Checksum: 16-bit modulo-2^16 sum of accepted in-map bytes only.

Optional Feature:
- DKONG_LOADER_CHECKSUM_EN defined:
  - O_CHECKSUM tracks the sum during LOAD and holds after it.
  - Completion additionally requires O_CHECKSUM==EXPECTED_SUM; mismatch sets O_ERR and goes to HOLD.
- Undefined:
  - No sum logic; O_CHECKSUM tied 0.
  - Completeness is the max_addr check only.

Decomposition:
- Package dkong_loader_pkg:
  - Region base/limit localparams.
  - Region index enum (CPU, SND, TILE, OBJ, PROM).
  - State enum (HOLD, LOAD, SETTLE, RUN).
  - Region count (5).
- Sub-module dkong_region_decode: combinational address → one-hot select plus relative offset. Instantiated once.

Test Plan:
- Power-up, no download → O_CORE_RESETn stays 0 and O_LOADED=0 for 10000 clocks.
- Full image 0x00000..0x082FF, then I_DN_ACTIVE falls →
  - O_LOADED=1, O_ERR=0.
  - O_CORE_RESETn rises exactly SETTLE_CYCLES+1 clocks after the fall.
  - Write to 0x05010 yields O_WR_SEL=5'b00100, O_WR_ADDR=0x0010 one clock later.
- Download stops at 0x07FFF → O_ERR=1, core reset held; a following complete download clears O_ERR and releases reset.
- Write to 0x08300 and 0x7FFFF during LOAD → no O_WR_SEL pulse; max_addr unchanged.
- In RUN, I_USER_RESET pulse of 3 clocks → reset asserted next clock, released SETTLE_CYCLES after the last high clock. I_DN_ACTIVE rising during SETTLE → state LOAD next clock.
- With DKONG_LOADER_CHECKSUM_EN and EXPECTED_SUM=16'h1234, complete image summing to 16'h1235 → O_ERR=1, O_CORE_RESETn stays 0.

Source files
------------

// File: rtl/dkong_loader_pkg.sv
// Shared definitions for the Donkey Kong ROM download sequencer:
// region map, region index and state encodings, offset helper.
package dkong_loader_pkg;

   localparam int REGION_COUNT = 5;
   localparam int ADDR_W       = 19;
   localparam int OFFS_W       = 15;

   // Region map of the flat download image, inclusive bounds
   localparam logic [ADDR_W-1:0] CPU_BASE   = 19'h00000;
   localparam logic [ADDR_W-1:0] CPU_LIMIT  = 19'h03FFF;
   localparam logic [ADDR_W-1:0] SND_BASE   = 19'h04000;
   localparam logic [ADDR_W-1:0] SND_LIMIT  = 19'h04FFF;
   localparam logic [ADDR_W-1:0] TILE_BASE  = 19'h05000;
   localparam logic [ADDR_W-1:0] TILE_LIMIT = 19'h05FFF;
   localparam logic [ADDR_W-1:0] OBJ_BASE   = 19'h06000;
   localparam logic [ADDR_W-1:0] OBJ_LIMIT  = 19'h07FFF;
   localparam logic [ADDR_W-1:0] PROM_BASE  = 19'h08000;
   localparam logic [ADDR_W-1:0] PROM_LIMIT = 19'h082FF;

   // Bit positions inside the one-hot write select
   typedef enum logic [2:0] {
      REG_CPU  = 3'd0,
      REG_SND  = 3'd1,
      REG_TILE = 3'd2,
      REG_OBJ  = 3'd3,
      REG_PROM = 3'd4
   } region_e;

   typedef enum logic [1:0] {
      ST_HOLD   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RUN    = 2'd3
   } state_e;

   // Byte offset inside a region; every region fits in 15 bits
   function automatic logic [OFFS_W-1:0] rel_offset(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] base);
      return OFFS_W'(addr - base);
   endfunction

endpackage

// File: rtl/dkong_region_decode.sv
// Combinational decode of a download address into a one-hot region
// select and the byte offset relative to that region's base.
module dkong_region_decode
   import dkong_loader_pkg::*;
(
   input  logic [ADDR_W-1:0]       addr,
   output logic [REGION_COUNT-1:0] sel,
   output logic [OFFS_W-1:0]       offset
);

   // Regions are contiguous from 0, so each upper bound alone picks the region
   always_comb begin
      sel    = '0;
      offset = '0;
      if (addr <= CPU_LIMIT) begin
         sel[REG_CPU] = 1'b1;
         offset       = rel_offset(addr, CPU_BASE);
      end else if (addr <= SND_LIMIT) begin
         sel[REG_SND] = 1'b1;
         offset       = rel_offset(addr, SND_BASE);
      end else if (addr <= TILE_LIMIT) begin
         sel[REG_TILE] = 1'b1;
         offset        = rel_offset(addr, TILE_BASE);
      end else if (addr <= OBJ_LIMIT) begin
         sel[REG_OBJ] = 1'b1;
         offset       = rel_offset(addr, OBJ_BASE);
      end else if (addr <= PROM_LIMIT) begin
         sel[REG_PROM] = 1'b1;
         offset        = rel_offset(addr, PROM_BASE);
      end
   end

endmodule

// File: rtl/dkong_rom_loader.sv
// ROM download sequencer for the Donkey Kong core: turns the HPS download
// stream into per-region write strobes and owns the core reset.
// Optional build macro DKONG_LOADER_CHECKSUM_EN: keeps a 16-bit byte sum of
// the accepted image and requires it to equal EXPECTED_SUM for completion.
module dkong_rom_loader
   import dkong_loader_pkg::*;
#(
   parameter int          SETTLE_CYCLES = 1024,
   parameter logic [15:0] EXPECTED_SUM  = 16'h0000
)(
   input  logic        I_CLK_24576M,
   input  logic        I_RESETn,
   input  logic        I_DN_ACTIVE,
   input  logic [18:0] I_DN_ADDR,
   input  logic [7:0]  I_DN_DATA,
   input  logic        I_DN_WR,
   input  logic        I_USER_RESET,
   output logic [14:0] O_WR_ADDR,
   output logic [7:0]  O_WR_DATA,
   output logic [4:0]  O_WR_SEL,
   output logic        O_CORE_RESETn,
   output logic        O_LOADED,
   output logic        O_ERR,
   output logic [15:0] O_CHECKSUM
);

   localparam int               CNT_W       = $clog2(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e                  state;
   logic [CNT_W-1:0]        settle_cnt;
   logic [ADDR_W-1:0]       max_addr;
   logic [ADDR_W-1:0]       max_next;
   logic [REGION_COUNT-1:0] dec_sel;
   logic [OFFS_W-1:0]       dec_offset;
   logic [REGION_COUNT-1:0] sel_p1;
   logic [OFFS_W-1:0]       addr_p1;
   logic [7:0]              data_p1;
   logic                    core_resetn;
   logic                    loaded;
   logic                    err;
   logic                    accept;
   logic                    enter_load;
   logic                    sum_ok;
   logic                    image_ok;

   dkong_region_decode u_decode (
      .addr   (I_DN_ADDR),
      .sel    (dec_sel),
      .offset (dec_offset)
   );

   // A write counts only while loading and only when it lands in the map
   assign accept     = (state == ST_LOAD) && I_DN_WR && (|dec_sel);
   assign enter_load = I_DN_ACTIVE && (state != ST_LOAD);
   // Includes a write arriving on the same clock as the end of the download
   assign max_next   = (accept && (I_DN_ADDR > max_addr)) ? I_DN_ADDR : max_addr;
   assign image_ok   = (max_next == PROM_LIMIT) && sum_ok;

`ifdef DKONG_LOADER_CHECKSUM_EN
   logic [15:0] sum;
   logic [15:0] sum_next;

   assign sum_next = accept ? (sum + {8'h00, I_DN_DATA}) : sum;
   assign sum_ok   = (sum_next == EXPECTED_SUM);

   // Byte sum of the current image; cleared on each new download, held after
   always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
      if (!I_RESETn) begin
         sum <= '0;
      end else if (enter_load) begin
         sum <= '0;
      end else begin
         sum <= sum_next;
      end
   end

   assign O_CHECKSUM = sum;
`else
   // The reference sum has no role without the checksum build
   logic [15:0] unused_sum_ref;
   assign unused_sum_ref = EXPECTED_SUM;
   assign sum_ok         = 1'b1;
   assign O_CHECKSUM     = '0;
`endif

   // Highest in-map address written during the current download
   always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
      if (!I_RESETn) begin
         max_addr <= '0;
      end else if (enter_load) begin
         max_addr <= '0;
      end else begin
         max_addr <= max_next;
      end
   end

   // Write port register: one-clock select pulse with offset and data
   always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
      if (!I_RESETn) begin
         sel_p1  <= '0;
         addr_p1 <= '0;
         data_p1 <= '0;
      end else begin
         sel_p1 <= accept ? dec_sel : '0;
         if (accept) begin
            addr_p1 <= dec_offset;
            data_p1 <= I_DN_DATA;
         end
      end
   end

   // Control FSM: core reset sequencing, load completion and error tracking
   always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
      if (!I_RESETn) begin
         state       <= ST_HOLD;
         settle_cnt  <= '0;
         core_resetn <= 1'b0;
         loaded      <= 1'b0;
         err         <= 1'b0;
      end else begin
         core_resetn <= 1'b0;
         case (state)
            ST_HOLD: begin
               if (I_DN_ACTIVE) begin
                  state <= ST_LOAD;
               end else if (loaded && !err) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= '0;
               end
            end
            ST_LOAD: begin
               if (!I_DN_ACTIVE) begin
                  if (image_ok) begin
                     loaded     <= 1'b1;
                     err        <= 1'b0;
                     state      <= ST_SETTLE;
                     settle_cnt <= '0;
                  end else begin
                     err   <= 1'b1;
                     state <= ST_HOLD;
                  end
               end
            end
            ST_SETTLE: begin
               if (I_DN_ACTIVE) begin
                  state <= ST_LOAD;
               end else if (I_USER_RESET) begin
                  settle_cnt <= '0;
               end else if (settle_cnt == SETTLE_LAST) begin
                  state       <= ST_RUN;
                  core_resetn <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (I_DN_ACTIVE) begin
                  state <= ST_LOAD;
               end else if (I_USER_RESET) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= '0;
               end else begin
                  core_resetn <= 1'b1;
               end
            end
            default: begin
               state <= ST_HOLD;
            end
         endcase
      end
   end

   assign O_WR_SEL      = sel_p1;
   assign O_WR_ADDR     = addr_p1;
   assign O_WR_DATA     = data_p1;
   assign O_CORE_RESETn = core_resetn;
   assign O_LOADED      = loaded;
   assign O_ERR         = err;

endmodule
